morse_frame_controller: RTL and testbench

MORSE_FRAME_CONTROLLER -- requirements
Module: morse_frame_controller

---
 rtl/morse_pkg.sv | 42 ++++
 rtl/morse_symbol_packer.sv | 54 +++++
 rtl/morse_frame_controller.sv | 131 +++++++++++++
 tb/tb_morse_frame_controller.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared Morse frame definitions: symbol codes, codeword constants, FSM states
// and a helper that writes one codeword into a numbered frame slot.
package morse_pkg;

  localparam int unsigned SLOTS   = 16;
  localparam int unsigned FIELDS  = 5;
  localparam int unsigned CW_W    = 10;
  localparam int unsigned FRAME_W = SLOTS * CW_W;
  localparam int unsigned ASCII_W = 128;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned LAT_W   = 4;
  localparam int unsigned PTR_W   = 3;

  localparam logic [1:0] SYM_DOT  = 2'b00;
  localparam logic [1:0] SYM_DASH = 2'b01;
  localparam logic [1:0] SYM_LE   = 2'b10;
  localparam logic [1:0] SYM_WE   = 2'b11;
  localparam logic [1:0] PAD      = 2'b11;

  localparam logic [CW_W-1:0] SPACE_CW   = {2'b10, {4{PAD}}};
  localparam logic [CW_W-1:0] INVALID_CW = {FIELDS{PAD}};

  typedef enum logic [1:0] {
    COLLECT,
    LAUNCH,
    CAPTURE,
    OUTPUT
  } state_e;

  // Slot k sits at bits [FRAME_W-1-CW_W*k -: CW_W]; idx >= SLOTS leaves the frame unchanged.
  function automatic logic [FRAME_W-1:0] put_slot(input logic [FRAME_W-1:0] frame,
                                                  input logic [CNT_W-1:0]   idx,
                                                  input logic [CW_W-1:0]    cw);
    logic [FRAME_W-1:0] r;
    r = frame;
    for (int k = 0; k < SLOTS; k++) begin
      if (idx == CNT_W'(k)) r[FRAME_W-1-CW_W*k -: CW_W] = cw;
    end
    return r;
  endfunction

endpackage

// File: rtl/morse_symbol_packer.sv
// Builds one letter codeword from dot/dash symbols; cw_c/has_sym_c show the
// letter including any symbol pushed this cycle so it can be closed immediately.
module morse_symbol_packer
  import morse_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            dash,
  input  logic            clear,
  output logic [CW_W-1:0] cw_c,
  output logic            has_sym_c
);

  logic [CW_W-1:0]  cw_q, cw_n;
  logic [PTR_W-1:0] ptr_q, ptr_n;
  logic             ovf_q, ovf_n;

  always_comb begin
    cw_n  = cw_q;
    ptr_n = ptr_q;
    ovf_n = ovf_q;
    if (push) begin
      if (ptr_q == PTR_W'(FIELDS)) begin
        ovf_n = 1'b1;
      end else begin
        for (int k = 0; k < FIELDS; k++) begin
          if (ptr_q == PTR_W'(k)) cw_n[CW_W-1-2*k -: 2] = {1'b0, dash};
        end
        ptr_n = ptr_q + PTR_W'(1);
      end
    end
    cw_c      = ovf_n ? INVALID_CW : cw_n;
    has_sym_c = (ptr_n != '0);
  end

  // Clear wins over push: a symbol closed in the same cycle is not kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cw_q  <= INVALID_CW;
      ptr_q <= '0;
      ovf_q <= 1'b0;
    end else if (clear) begin
      cw_q  <= INVALID_CW;
      ptr_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cw_q  <= cw_n;
      ptr_q <= ptr_n;
      ovf_q <= ovf_n;
    end
  end

endmodule

// File: rtl/morse_frame_controller.sv
// Collects Morse letters into 16-slot frames, presents each frame to an external
// translator for TRANSLATE_LAT cycles and returns the ASCII result with a handshake.
module morse_frame_controller
  import morse_pkg::*;
#(
  parameter int unsigned TRANSLATE_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sym_valid,
  input  logic [1:0]         sym_data,
  output logic               sym_ready,
  input  logic               flush,
  output logic [FRAME_W-1:0] seq_bus,
  input  logic [ASCII_W-1:0] letters_in,
  output logic [ASCII_W-1:0] out_letters,
  output logic [CNT_W-1:0]   out_count,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy
);

  state_e             state_q, state_n;
  logic [FRAME_W-1:0] frame_n;
  logic [CNT_W-1:0]   slot_q, slot_n;
  logic               pend_q, pend_n;
  logic [LAT_W-1:0]   lat_q, lat_n;
  logic [ASCII_W-1:0] letters_n;
  logic [CNT_W-1:0]   count_n;
  logic               accept, end_sym, pk_push, pk_dash, pk_clear, pk_has_sym, close;
  logic [CW_W-1:0]    pk_cw;

  assign accept   = sym_valid && sym_ready;
  assign end_sym  = accept && (sym_data == SYM_LE || sym_data == SYM_WE);
  assign pk_push  = accept && (sym_data == SYM_DOT || sym_data == SYM_DASH);
  assign pk_dash  = (sym_data == SYM_DASH);
  assign pk_clear = (state_q == COLLECT) && (end_sym || flush);

  morse_symbol_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .push      (pk_push),
    .dash      (pk_dash),
    .clear     (pk_clear),
    .cw_c      (pk_cw),
    .has_sym_c (pk_has_sym)
  );

  always_comb begin
    state_n   = state_q;
    frame_n   = seq_bus;
    slot_n    = slot_q;
    pend_n    = pend_q;
    lat_n     = lat_q;
    letters_n = out_letters;
    count_n   = out_count;
    close     = 1'b0;
    case (state_q)
      COLLECT: begin
        // Symbol first, then flush: a mark arriving with flush is closed with its letter.
        close = pk_has_sym && (end_sym || flush);
        if (close) begin
          frame_n = put_slot(frame_n, slot_n, pk_cw);
          slot_n  = slot_n + CNT_W'(1);
        end
        if (accept && sym_data == SYM_WE) begin
          if (slot_n == CNT_W'(SLOTS)) begin
            pend_n = 1'b1;
          end else begin
            frame_n = put_slot(frame_n, slot_n, SPACE_CW);
            slot_n  = slot_n + CNT_W'(1);
          end
        end
        if (slot_n == CNT_W'(SLOTS) || (flush && slot_n != '0)) begin
          state_n = LAUNCH;
          lat_n   = '0;
        end
      end
      LAUNCH: begin
        if (lat_q == LAT_W'(TRANSLATE_LAT)) state_n = CAPTURE;
        else lat_n = lat_q + LAT_W'(1);
      end
      CAPTURE: begin
        letters_n = letters_in;
        count_n   = slot_q;
        frame_n   = '1;
        slot_n    = '0;
        lat_n     = '0;
        state_n   = OUTPUT;
      end
      OUTPUT: begin
        if (out_ready) begin
          state_n = COLLECT;
          if (pend_q) begin
            frame_n = put_slot(frame_n, '0, SPACE_CW);
            slot_n  = CNT_W'(1);
            pend_n  = 1'b0;
          end
        end
      end
      default: state_n = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= COLLECT;
      seq_bus     <= '1;
      slot_q      <= '0;
      pend_q      <= 1'b0;
      lat_q       <= '0;
      out_letters <= '0;
      out_count   <= '0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      sym_ready   <= 1'b0;
    end else begin
      state_q     <= state_n;
      seq_bus     <= frame_n;
      slot_q      <= slot_n;
      pend_q      <= pend_n;
      lat_q       <= lat_n;
      out_letters <= letters_n;
      out_count   <= count_n;
      out_valid   <= (state_n == OUTPUT);
      busy        <= (state_n != COLLECT);
      sym_ready   <= (state_n == COLLECT) && !pend_n;
    end
  end

endmodule

// File: tb/tb_morse_frame_controller.sv
// Bench for morse_frame_controller: letter-encoding table, directed corner cases and
// random symbol streams checked against a queue-based frame model.
module tb_morse_frame_controller;

  localparam int LAT = 2;
  localparam logic [1:0] DOT = 2'b00, DASH = 2'b01, LE = 2'b10, WE = 2'b11;
  localparam logic [9:0] SPACE = 10'b1011111111;

  logic         clk, rst, sym_valid, flush, sym_ready, out_valid, out_ready, busy;
  logic [1:0]   sym_data;
  logic [159:0] seq_bus;
  logic [127:0] letters_in, out_letters;
  logic [4:0]   out_count;
  logic         ready_req, auto_ready, rnd_ready;
  logic [127:0] xl_pipe [LAT];

  int checks = 0;
  int failures = 0;

  typedef struct { logic [159:0] frame; int count; } exp_t;
  exp_t       exp_q[$];
  logic       marks[$];
  logic [9:0] slots[$];

  morse_frame_controller #(.TRANSLATE_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .sym_valid(sym_valid), .sym_data(sym_data), .sym_ready(sym_ready),
    .flush(flush), .seq_bus(seq_bus), .letters_in(letters_in), .out_letters(out_letters),
    .out_count(out_count), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Translator stand-in: per-slot byte derived from the codeword, delayed LAT cycles.
  function automatic logic [127:0] xlate(input logic [159:0] f);
    logic [127:0] r;
    logic [9:0]   cw;
    for (int k = 0; k < 16; k++) begin
      cw = f[159-10*k -: 10];
      r[127-8*k -: 8] = cw[7:0] ^ {cw[9:8], 6'(k)};
    end
    return r;
  endfunction

  always @(posedge clk) begin
    xl_pipe[0] <= xlate(seq_bus);
    for (int i = 1; i < LAT; i++) xl_pipe[i] <= xl_pipe[i-1];
  end
  assign letters_in = xl_pipe[LAT-1];
  assign out_ready  = auto_ready ? rnd_ready : ready_req;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: the letter/space stream is a codeword queue cut into frames of 16.
  function automatic void m_emit();
    exp_t e;
    e.frame = '1;
    for (int i = 0; i < slots.size(); i++) e.frame[159-10*i -: 10] = slots[i];
    e.count = slots.size();
    exp_q.push_back(e);
    slots.delete();
  endfunction

  function automatic void m_store(input logic [9:0] cw);
    slots.push_back(cw);
    if (slots.size() == 16) m_emit();
  endfunction

  function automatic void m_close();
    logic [9:0] cw;
    if (marks.size() == 0) return;
    cw = '1;
    if (marks.size() <= 5)
      for (int i = 0; i < marks.size(); i++) cw[9-2*i -: 2] = {1'b0, marks[i]};
    m_store(cw);
    marks.delete();
  endfunction

  function automatic void model_apply(input logic v, input logic [1:0] s, input logic fl);
    if (v) begin
      case (s)
        DOT, DASH: marks.push_back(s[0]);
        LE:        m_close();
        default: begin m_close(); m_store(SPACE); end
      endcase
    end
    if (fl) begin
      m_close();
      if (slots.size() > 0) m_emit();
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    marks.delete();
    slots.delete();
  endfunction

  // Called at a negedge; waits for sym_ready, drives one cycle of symbol and/or flush.
  task automatic send(input logic v, input logic [1:0] s, input logic fl);
    int g = 0;
    while (!sym_ready && g < 400) begin @(negedge clk); g++; end
    if (!sym_ready) begin chk("send_wait_ready", sym_ready, 1); return; end
    sym_valid = v; sym_data = s; flush = fl;
    model_apply(v, s, fl);
    @(negedge clk);
    sym_valid = 0; sym_data = 2'b00; flush = 0;
  endtask

  task automatic wait_valid();
    int g = 0;
    while (!out_valid && g < 100) begin @(negedge clk); g++; end
    if (!out_valid) chk("wait_out_valid", out_valid, 1);
  endtask

  task automatic handshake();
    wait_valid();
    ready_req = 1;
    @(negedge clk);
    ready_req = 0;
  endtask

  initial begin
    rnd_ready = 0;
    forever begin @(negedge clk); rnd_ready = ($urandom_range(0, 2) == 0); end
  end

  // Every launch and every returned frame is compared with the model's next frame.
  initial begin
    logic busy_d, ov_d;
    busy_d = 0; ov_d = 0;
    forever begin
      @(negedge clk);
      if (!rst && busy && !busy_d) begin
        if (exp_q.size() == 0) chk("unexpected_launch", 1, 0);
        else chk("launch_seq_bus", seq_bus, exp_q[0].frame);
      end
      if (!rst && out_valid && !ov_d) begin
        if (exp_q.size() == 0) chk("unexpected_out_valid", 1, 0);
        else begin
          chk("out_count", out_count, exp_q[0].count);
          chk("out_letters", out_letters, xlate(exp_q[0].frame));
          void'(exp_q.pop_front());
        end
      end
      busy_d = busy; ov_d = out_valid;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  typedef struct { int n; logic [7:0] pat; logic le; logic [9:0] cw; } vec_t;
  vec_t vecs[10];

  initial begin
    logic [159:0] e;
    logic [127:0] held;
    logic         bad_rdy, bad_hold;
    int           k;
    logic [1:0]   s;
    logic         fl;
    int           r;

    // n marks (bit i of pat: 1 = dash), closed by LE+flush, or by flush on the last mark.
    vecs[0] = '{1, 8'h00, 1'b1, 10'b0011111111};
    vecs[1] = '{1, 8'h01, 1'b1, 10'b0111111111};
    vecs[2] = '{2, 8'h02, 1'b1, 10'b0001111111};
    vecs[3] = '{5, 8'h00, 1'b1, 10'b0000000000};
    vecs[4] = '{5, 8'h1F, 1'b1, 10'b0101010101};
    vecs[5] = '{6, 8'h00, 1'b1, 10'b1111111111};
    vecs[6] = '{7, 8'h55, 1'b1, 10'b1111111111};
    vecs[7] = '{4, 8'h05, 1'b1, 10'b0100010011};
    vecs[8] = '{3, 8'h01, 1'b1, 10'b0100001111};
    vecs[9] = '{2, 8'h03, 1'b0, 10'b0101111111};

    rst = 0; sym_valid = 0; sym_data = 0; flush = 0; ready_req = 0; auto_ready = 0;
    #2 rst = 1;
    @(negedge clk);
    chk("rst_seq_bus", seq_bus, '1);
    chk("rst_out_letters", out_letters, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sym_ready", sym_ready, 0);
    rst = 0;
    @(negedge clk);
    chk("post_rst_sym_ready", sym_ready, 1);

    // Letter encoding table
    foreach (vecs[v]) begin
      for (int i = 0; i < vecs[v].n; i++)
        send(1, vecs[v].pat[i] ? DASH : DOT, !vecs[v].le && (i == vecs[v].n - 1));
      if (vecs[v].le) send(1, LE, 1);
      e = '1;
      e[159:150] = vecs[v].cw;
      chk($sformatf("table%0d_seq_bus", v), seq_bus, e);
      handshake();
    end

    // S O S then flush
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < 3; i++) send(1, (l == 1) ? DASH : DOT, 0);
      send(1, LE, 0);
    end
    send(0, DOT, 1);
    e = '1;
    e[159:130] = 30'b000000111101010111110000001111;
    chk("sos_seq_bus", seq_bus, e);
    wait_valid();
    chk("sos_count", out_count, 3);
    handshake();

    // 16 letters E launch on their own; out_valid LAT+2 edges after slot 15 write
    for (int l = 0; l < 16; l++) begin send(1, DOT, 0); send(1, LE, 0); end
    chk("auto_launch_busy", busy, 1);
    e = {16{10'b0011111111}};
    chk("auto_launch_seq_bus", seq_bus, e);
    k = 0;
    while (!out_valid && k < 50) begin @(negedge clk); k++; end
    chk("launch_latency", k, LAT + 2);
    chk("auto_count", out_count, 16);
    handshake();

    // 15 letters, then a letter closed by word-end: space carried into the next frame
    for (int l = 0; l < 15; l++) begin send(1, DASH, 0); send(1, LE, 0); end
    send(1, DOT, 0);
    send(1, WE, 0);
    bad_rdy = 0;
    k = 0;
    while (!out_valid && k < 50) begin
      if (sym_ready) bad_rdy = 1;
      @(negedge clk); k++;
    end
    chk("pend_sym_ready_low", bad_rdy, 0);
    chk("pend_count", out_count, 16);
    handshake();
    chk("pend_slot0_space", seq_bus[159:150], SPACE);
    chk("pend_sym_ready_back", sym_ready, 1);
    send(0, DOT, 1);
    wait_valid();
    chk("space_frame_count", out_count, 1);
    handshake();

    // Empty letter-ends consume no slot
    send(1, LE, 0); send(1, DOT, 0); send(1, LE, 0); send(1, LE, 0);
    send(1, DASH, 0); send(1, LE, 1);
    wait_valid();
    chk("empty_le_count", out_count, 2);
    handshake();

    // Back-pressure: output held, symbols blocked, flush dropped
    send(1, DOT, 0); send(1, LE, 1);
    wait_valid();
    held = out_letters;
    bad_hold = 0; bad_rdy = 0;
    for (int i = 0; i < 10; i++) begin
      flush = i[0];
      @(negedge clk);
      if (!out_valid || out_letters !== held) bad_hold = 1;
      if (sym_ready) bad_rdy = 1;
    end
    flush = 0;
    chk("hold_stable", bad_hold, 0);
    chk("hold_sym_ready_low", bad_rdy, 0);
    handshake();
    repeat (3) @(negedge clk);
    chk("flush_dropped_busy", busy, 0);

    // Reset during LAUNCH discards the frame
    send(1, DASH, 0); send(1, LE, 1);
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst = 1;
    model_reset();
    #1;
    chk("mid_rst_seq_bus", seq_bus, '1);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst = 0;
    bad_hold = 0;
    repeat (LAT + 6) begin @(negedge clk); if (out_valid) bad_hold = 1; end
    chk("no_valid_after_rst", bad_hold, 0);

    // Random symbol stream with random consumer back-pressure
    auto_ready = 1;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 30) s = DOT; else if (r < 60) s = DASH; else if (r < 88) s = LE; else s = WE;
      fl = (s != WE) && ($urandom_range(0, 24) == 0);
      send(1, s, fl);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    send(1, LE, 1);
    k = 0;
    while (exp_q.size() != 0 && k < 500) begin @(negedge clk); k++; end
    chk("random_drain", exp_q.size(), 0);
    auto_ready = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
